// File: rtl/round_seq_fsm.sv
// round_seq_fsm: load/round enable sequencer for an iterative WIDTH-bit datapath register
// Optional abort input is compiled in when ROUND_SEQ_ABORT_EN is defined.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   start     begin an operation (IDLE, or DONE together with ack)
//   ack       consumer accepts the result held in DONE
//   abort     (ROUND_SEQ_ABORT_EN only) cancel the operation from LOAD or RUN
//   din       initial value captured into dout during LOAD
//   round_in  next-round value from the external round logic
//   load_en   high during LOAD
//   round_en  high during RUN
//   round_idx current round number, 0..ROUNDS-1
//   busy      high in LOAD and RUN
//   done      high in DONE; dout is valid while high
//   dout      datapath register
module round_seq_fsm #(
    parameter int WIDTH  = 64,
    parameter int ROUNDS = 24,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
`ifdef ROUND_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] round_in,
    output logic             load_en,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);
    generate
        if (ROUNDS < 1 || (64'd1 << CNT_W) < 64'(ROUNDS)) begin : g_bad_cfg
            $error("round_seq_fsm: ROUNDS must be in 1..2**CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] idx_next;
    logic [WIDTH-1:0] dout_next;
    logic             abort_i;

`ifdef ROUND_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            round_idx <= '0;
            dout      <= '0;
        end else begin
            state     <= state_next;
            round_idx <= idx_next;
            dout      <= dout_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = round_idx;
        dout_next  = dout;
        case (state)
            IDLE: state_next = start ? LOAD : IDLE;
            LOAD: begin
                idx_next   = '0;
                state_next = abort_i ? IDLE : RUN;
                dout_next  = abort_i ? dout : din;
            end
            RUN: begin
                // abort wins over completion and leaves dout untouched
                if (abort_i) begin
                    idx_next   = '0;
                    state_next = IDLE;
                end else begin
                    dout_next  = round_in;
                    idx_next   = (round_idx == LAST) ? '0 : round_idx + 1'b1;
                    state_next = (round_idx == LAST) ? DONE : RUN;
                end
            end
            DONE: state_next = ack ? (start ? LOAD : IDLE) : DONE;
            default: state_next = IDLE;
        endcase
    end

    assign load_en  = (state == LOAD);
    assign round_en = (state == RUN);
    assign busy     = (state == LOAD) || (state == RUN);
    assign done     = (state == DONE);
endmodule

// File: doc/round_seq_fsm.md
Name: round_seq_fsm

Overview:
- Parametrised successor to the fixed three-state enable sequencer.
- Drives load and round enables for a WIDTH-bit iterative datapath register over a programmable number of rounds.
- Start/done/ack handshake toward the controlling block.
- Owns the state register (dout) fed from external round logic (round_in).

Parameters:
WIDTH, 64, width of din, round_in and dout.
ROUNDS, 24, number of RUN cycles per operation; legal range 1..2^CNT_W.
CNT_W, 5, width of round_idx; elaboration error if 2^CNT_W < ROUNDS.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
start  input  1  request new operation; honoured only in IDLE, or in DONE together with ack.
ack  input  1  consumer accepts result; meaningful only in DONE.
din  input  WIDTH  initial value loaded into dout in LOAD.
round_in  input  WIDTH  next-round value from external combinational round logic (function of dout, round_idx).
load_en  output  1  high exactly during LOAD.
round_en  output  1  high during every RUN cycle.
round_idx  output  CNT_W  current round number, 0..ROUNDS-1.
busy  output  1  high in LOAD and RUN.
done  output  1  high in DONE; dout valid while high.
dout  output  WIDTH  datapath register.

Behaviour:
- Reset (reset==0 at rising edge): state=IDLE, round_idx=0, dout=0. All outputs low/zero from the following cycle. Reset overrides every other input in any state, including mid-RUN.
- Outputs load_en, round_en, busy, done decoded from state only (Moore); no combinational path from inputs.
- IDLE: busy=0, done=0. start=1 -> LOAD. Otherwise stay.
- LOAD (one cycle): load_en=1, busy=1. At edge: dout<=din, round_idx<=0, -> RUN.
- RUN: round_en=1, busy=1. At each edge: dout<=round_in.
  - round_idx<ROUNDS-1: round_idx<=round_idx+1, stay in RUN.
  - round_idx==ROUNDS-1: round_idx<=0, -> DONE.
  - ROUNDS=1: RUN lasts exactly one cycle.
- DONE: done=1, dout held.
  - ack=1, start=0 -> IDLE.
  - ack=1, start=1 -> LOAD (back-to-back, no IDLE bubble).
  - ack=0: stay in DONE indefinitely; start ignored.
- start in LOAD/RUN ignored, not queued.
- Latency (start sampled at edge t):
  - load_en high during cycle t..t+1.
  - round_en high for ROUNDS cycles starting at edge t+1.
  - done rises at edge t+1+ROUNDS.
- round_idx never exceeds ROUNDS-1; no arithmetic overflow for legal CNT_W.
- dout updates only in LOAD and RUN, and on reset.

Optional Feature:
- Macro: ROUND_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit, after ack).
  - abort=1 in LOAD or RUN -> IDLE at next edge; round_idx<=0; dout keeps last value (not updated that edge); done never asserts for that operation.
  - abort has priority over round completion and over start.
  - abort ignored in IDLE and DONE.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
1. reset=0 two cycles with start=1 -> state IDLE, dout=0, all enables/done 0; release reset, start=0 -> remains idle.
2. ROUNDS=4, din=64'h1, round_in=dout+1 (bench model), start pulse -> load_en 1 cycle; round_en 4 cycles with round_idx 0,1,2,3; done rises 5 cycles after start edge; dout=64'h5.
3. In DONE hold ack=0 for 10 cycles with start=1 -> done stays 1, dout stable, no load_en; then ack=1 -> IDLE next cycle.
4. In DONE assert ack=1 and start=1 with din=64'hA -> LOAD next cycle, dout=64'hA; second done after ROUNDS further cycles.
5. reset=0 while round_idx=2 -> next cycle IDLE, round_idx=0, dout=0, round_en=0; subsequent start runs full ROUNDS.
6. ROUNDS=1 and, with ROUND_SEQ_ABORT_EN defined, abort=1 at round_idx=1 of a ROUNDS=4 run:
   - ROUNDS=1 -> exactly one round_en cycle.
   - abort run -> IDLE next cycle, done never asserted, dout equals value after round 0.
